// File: rtl/fp_add_arbiter.sv
// Two-port round-robin front end for a shared pipelined fp32 adder.
// Tracks in-flight tags to route each sum back to its requester and caps per-port occupancy.
module fp_add_arbiter #(
   parameter int LATENCY = 4,
   parameter int MAX_OUT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_x,
   input  logic [31:0] req0_y,
   input  logic        req0_sub,
   input  logic [2:0]  req0_rm,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_x,
   input  logic [31:0] req1_y,
   input  logic        req1_sub,
   input  logic [2:0]  req1_rm,
   output logic [31:0] add_x,
   output logic [31:0] add_y,
   output logic        add_sub,
   output logic [2:0]  add_rm,
   input  logic [31:0] add_sum,
   input  logic [4:0]  add_flags,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_sum,
   output logic [4:0]  rsp0_flags,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_sum,
   output logic [4:0]  rsp1_flags,
   output logic        busy
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

   logic               ptr_q, ptr_d;
   logic [3:0]         cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic [LATENCY-1:0] tag_v_q, tag_v_d, tag_id_q, tag_id_d;
   logic               ret0, ret1, elig0, elig1, gnt0, gnt1, xfer;

   // A retiring response frees a slot in the same cycle, so a full port can still be granted.
   always_comb begin
      ret0  = tag_v_q[LATENCY-1] & ~tag_id_q[LATENCY-1];
      ret1  = tag_v_q[LATENCY-1] &  tag_id_q[LATENCY-1];
      elig0 = req0_valid & ~flush & ~rst & ((cnt0_q < MAX_CNT) | ret0);
      elig1 = req1_valid & ~flush & ~rst & ((cnt1_q < MAX_CNT) | ret1);
      gnt0  = elig0 & (~elig1 | ~ptr_q);
      gnt1  = elig1 & (~elig0 |  ptr_q);
      xfer  = gnt0 | gnt1;
   end

   always_comb begin
      add_x   = '0;
      add_y   = '0;
      add_sub = 1'b0;
      add_rm  = '0;
      if (gnt0) begin
         add_x   = req0_x;
         add_y   = req0_y;
         add_sub = req0_sub;
         add_rm  = req0_rm;
      end else if (gnt1) begin
         add_x   = req1_x;
         add_y   = req1_y;
         add_sub = req1_sub;
         add_rm  = req1_rm;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign rsp0_valid = ret0 & ~flush & ~rst;
   assign rsp1_valid = ret1 & ~flush & ~rst;
   assign rsp0_sum   = add_sum;
   assign rsp1_sum   = add_sum;
   assign rsp0_flags = add_flags;
   assign rsp1_flags = add_flags;
   assign busy       = (|tag_v_q) & ~rst;

   always_comb begin
      tag_v_d     = '0;
      tag_id_d    = '0;
      tag_v_d[0]  = xfer;
      tag_id_d[0] = gnt1;
      for (int unsigned i = 1; i < LATENCY; i++) begin
         tag_v_d[i]  = tag_v_q[i-1];
         tag_id_d[i] = tag_id_q[i-1];
      end
      cnt0_d = cnt0_q + {3'b000, gnt0} - {3'b000, ret0};
      cnt1_d = cnt1_q + {3'b000, gnt1} - {3'b000, ret1};
      ptr_d  = xfer ? ~gnt1 : ptr_q;
      if (flush) begin
         tag_v_d = '0;
         cnt0_d  = '0;
         cnt1_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q    <= 1'b0;
         cnt0_q   <= '0;
         cnt1_q   <= '0;
         tag_v_q  <= '0;
         tag_id_q <= '0;
      end else begin
         ptr_q    <= ptr_d;
         cnt0_q   <= cnt0_d;
         cnt1_q   <= cnt1_d;
         tag_v_q  <= tag_v_d;
         tag_id_q <= tag_id_d;
      end
   end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 SHALL provide parameter LATENCY, default 4, giving fp32_adder_pipe cycles from operand capture to valid sum.
REQ-002 SHALL provide parameter MAX_OUT, default 4, giving the per-requester limit on in-flight operations (range 1..15).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 flush  input  1  discards all in-flight operations.
REQ-006 reqN_valid  input  1  request from requester N (N=0,1).
REQ-007 reqN_ready  output  1  grant to requester N; a transfer occurs when valid and ready are both high at a rising edge.
REQ-008 reqN_x, reqN_y  input  32  IEEE 754 single operands.
REQ-009 reqN_sub  input  1  subtract when high.
REQ-010 reqN_rm  input  3  rounding mode (RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100).
REQ-011 add_x, add_y  output  32  operands to the shared adder.
REQ-012 add_sub, add_rm  output  1, 3  operation controls to the shared adder.
REQ-013 add_sum  input  32  adder result.
REQ-014 add_flags  input  5  adder flags, ordered {NV,DZ,OF,UF,NX}.
REQ-015 rspN_valid  output  1  single-cycle response pulse to requester N; not back-pressurable.
REQ-016 rspN_sum, rspN_flags  output  32, 5  result and flags, qualified by rspN_valid.
REQ-017 busy  output  1  high while any operation is in flight.

Function
REQ-018 SHALL hold a round-robin pointer ptr (1 bit); when both requests are eligible, SHALL grant port ptr.
REQ-019 When only one request is eligible, SHALL grant it regardless of ptr.
REQ-020 After any transfer from port i, ptr SHALL become ~i; with no transfer, ptr SHALL hold.
REQ-021 Port N SHALL be eligible when reqN_valid=1, flush=0, rst=0, and either cntN<MAX_OUT or a port-N response retires in the same cycle.
REQ-022 reqN_ready SHALL be combinational and asserted only for the single granted port; it SHALL NOT depend on reqN_valid of the other port beyond the arbitration rule.
REQ-023 add_x, add_y, add_sub and add_rm SHALL pass the granted port's inputs combinationally; with no grant they SHALL be all zeros.
REQ-024 SHALL keep a LATENCY-deep tag shift register of {valid,id}; stage 0 SHALL load {transfer, granted id} every cycle, and the register SHALL shift each cycle.
REQ-025 rspN_valid SHALL be high when the tag valid bit at stage LATENCY-1 is set with id=N. The response therefore appears exactly LATENCY cycles after the transfer cycle, and at most one port responds per cycle.
REQ-026 rspN_sum SHALL equal add_sum and rspN_flags SHALL equal add_flags combinationally, for both N.
REQ-027 Each per-port counter cntN (4 bits) SHALL increment on a port-N transfer and decrement on a port-N response. A simultaneous transfer and response SHALL leave cntN unchanged, and cntN SHALL never exceed MAX_OUT.
REQ-028 Sustained throughput SHALL be one transfer per cycle when MAX_OUT >= LATENCY.
REQ-029 busy SHALL be the OR of all tag valid bits.
REQ-030 flush=1 SHALL hold both readies low in that cycle and SHALL clear all tag valid bits and both counters at the edge; ptr SHALL hold.
REQ-031 Any response scheduled for a flush cycle SHALL be suppressed (rspN_valid=0).

Reset
REQ-032 rst=1 SHALL, at the edge, clear all tag bits, cnt0, cnt1 and ptr (ptr=0).
REQ-033 While rst=1, reqN_ready=0, rspN_valid=0, busy=0, and add_x, add_y, add_sub and add_rm SHALL be zero.
REQ-034 rst asserted mid-operation SHALL discard all in-flight results; no response from before reset SHALL appear after it.
REQ-035 Operations issued in the first cycle after rst deasserts SHALL be accepted normally.

Verification
REQ-036 req0 transfers x=3F800000, y=3F800000, sub=0, RNE at cycle T, with the adder connected -> rsp0_valid=1 only at T+4, rsp0_sum=40000000, rsp1_valid=0 throughout.
REQ-037 Both ports valid continuously from reset, req0 = 5.0-3.0 and req1 = 2.5+3.5 -> grants alternate 0,1,0,1. Port 0 receives 40000000 and port 1 receives 40C00000 on alternate cycles, each pulse 4 cycles after its grant.
REQ-038 MAX_OUT=2, only req0 valid continuously -> ready is high 2 cycles then low 2 cycles, repeating. cnt0 never exceeds 2, and each re-grant coincides with a response.
REQ-039 MAX_OUT=4, req0 continuous -> ready never drops after the first transfer; the cycle with cnt0=4 and a retiring response still transfers.
REQ-040 Three ops in flight, then flush for 1 cycle -> no rsp pulses afterwards, busy=0 next cycle, cnt0=cnt1=0, and a new op 1 cycle later returns 4 cycles after its transfer.
REQ-041 rst pulsed 2 cycles after issuing 7F800000+FF800000 -> no response ever appears, ptr=0, and the next req1-only op is granted immediately.
